// File: rtl/pipe_pkg.sv
// Pipeline control package: default geometry of the flat RISC-V core and
// symbolic stage indices shared by the control block and the stage modules.
package pipe_pkg;

  // Stage index constants (fetch .. writeback)
  localparam int ST_FE = 0;
  localparam int ST_DC = 1;
  localparam int ST_EX = 2;
  localparam int ST_ME = 3;
  localparam int ST_WB = 4;

  // Default geometry: five stages, redirects resolved in execute
  localparam int DEF_STAGES = ST_WB + 1;
  localparam int DEF_RS     = ST_EX;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: W-bit up counter for performance statistics.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset, clears the count
//   clr    - synchronous clear, wins over inc
//   inc    - add one this cycle; holds at all-ones instead of wrapping
//   cnt    - current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: valid/ready/advance generation for an in-order pipeline of
// STAGES stages (0 = fetch, STAGES-1 = writeback), with redirect flushing
// of stages 0..RS and saturating per-stage stall counters.
// Ports:
//   clk, rst_n    - clock and synchronous active-low reset
//   fe_valid      - front end offers an op to stage 0
//   fe_ready      - stage 0 accepts this cycle (== advance[0])
//   stall[i]      - op in stage i cannot leave this cycle
//   redirect      - stage RS reports a taken branch/jump
//   flush         - redirect qualified by stage RS leaving (combinational)
//   valid[i]      - stage i holds a live op
//   advance[i]    - load enable for the stage i datapath register
//   retire        - op in the last stage completes this cycle
//   clr_cnt       - synchronous clear of all counters
//   stall_cnt     - stage i count in [i*CNT_W +: CNT_W]
//   flush_cnt     - number of qualified redirects
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int RS     = DEF_RS,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fe_valid,
  output logic                    fe_ready,
  input  logic [STAGES-1:0]       stall,
  input  logic                    redirect,
  output logic                    flush,
  output logic [STAGES-1:0]       valid,
  output logic [STAGES-1:0]       advance,
  output logic                    retire,
  input  logic                    clr_cnt,
  output logic [STAGES*CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] w_leave;
  logic [STAGES-1:0] w_ready;
  logic              w_flush;

  // Ready chain built from the last stage back to fetch. Each block keeps its
  // own ready signal so the chain is a plain series of separate nets.
  for (genvar k = 0; k < STAGES; k++) begin : g_rdy
    localparam int J = STAGES - 1 - k;
    logic w_nrdy;
    logic w_lv;
    logic w_rd;
    if (k == 0) begin : g_tail
      assign w_nrdy = 1'b1;
    end else begin : g_link
      assign w_nrdy = g_rdy[k-1].w_rd;
    end
    assign w_lv       = r_valid[J] & ~stall[J] & w_nrdy;
    assign w_rd       = ~r_valid[J] | w_lv;
    assign w_leave[J] = w_lv;
    assign w_ready[J] = w_rd;
  end

  assign w_flush  = redirect & w_leave[RS];
  assign flush    = w_flush;
  assign advance  = w_ready;
  assign fe_ready = w_ready[ST_FE];
  assign retire   = w_leave[STAGES-1];
  assign valid    = r_valid;

  // A stage that advances takes the op leaving the stage above it (not merely
  // that stage's valid), so a stalled upstream op becomes a bubble below it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (w_ready[i]) begin
          if (i == 0) begin
            r_valid[i] <= fe_valid & ~(w_flush && (RS >= 0));
          end else begin
            r_valid[i] <= w_leave[i-1] & ~(w_flush && (i <= RS));
          end
        end
      end
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_cnt),
      .inc   (r_valid[s] & ~w_leave[s]),
      .cnt   (stall_cnt[s*CNT_W +: CNT_W])
    );
  end

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (w_flush),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with STAGES=5, RS=2, CNT_W=4.
module tb_pipe_ctrl;

  localparam int ST = 5;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             fe_valid;
  logic             fe_ready;
  logic [ST-1:0]    stall;
  logic             redirect;
  logic             flush;
  logic [ST-1:0]    valid;
  logic [ST-1:0]    advance;
  logic             retire;
  logic             clr_cnt;
  logic [ST*CW-1:0] stall_cnt;
  logic [CW-1:0]    flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(ST), .RS(2), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fe_valid  (fe_valid),
    .fe_ready  (fe_ready),
    .stall     (stall),
    .redirect  (redirect),
    .flush     (flush),
    .valid     (valid),
    .advance   (advance),
    .retire    (retire),
    .clr_cnt   (clr_cnt),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs change 1 time unit after it.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; fe_valid = 1'b0; stall = '0; redirect = 1'b0; clr_cnt = 1'b0;
    step(2);
    settle();
    chk("rst_valid",   32'(valid),     32'h0);
    chk("rst_stall",   32'(stall_cnt), 32'h0);
    chk("rst_flcnt",   32'(flush_cnt), 32'h0);
    chk("rst_advance", 32'(advance),   32'h1f);
    chk("rst_feready", 32'(fe_ready),  32'h1);
    chk("rst_retire",  32'(retire),    32'h0);
    chk("rst_flush",   32'(flush),     32'h0);

    // Fill
    rst_n = 1'b1; fe_valid = 1'b1;
    step(1); chk("fill1", 32'(valid), 32'h01);
    step(1); chk("fill2", 32'(valid), 32'h03);
    step(1); chk("fill3", 32'(valid), 32'h07);
    step(1); chk("fill4", 32'(valid), 32'h0f);
    step(1); chk("fill5", 32'(valid), 32'h1f);
    settle();
    chk("fill_retire", 32'(retire),    32'h1);
    chk("fill_scnt",   32'(stall_cnt), 32'h0);
    step(1);
    chk("fill_retire2", 32'(retire), 32'h1);

    // Mid stall on stage 2 for three cycles
    stall = 5'b00100;
    settle();
    chk("ms_feready1", 32'(fe_ready), 32'h0);
    chk("ms_advance",  32'(advance),  32'h18);
    step(1);
    chk("ms_valid1",   32'(valid),    32'h17);
    chk("ms_feready2", 32'(fe_ready), 32'h0);
    step(1);
    chk("ms_valid2",   32'(valid),    32'h07);
    chk("ms_feready3", 32'(fe_ready), 32'h0);
    step(1);
    chk("ms_scnt",     32'(stall_cnt), 32'h00333);
    stall = '0;
    step(2);
    chk("ms_refull", 32'(valid), 32'h1f);

    // Flush on a full pipe
    redirect = 1'b1;
    settle();
    chk("fl_flush", 32'(flush), 32'h1);
    step(1);
    redirect = 1'b0;
    chk("fl_valid", 32'(valid),     32'h18);
    chk("fl_cnt",   32'(flush_cnt), 32'h1);

    // Refill and clear counters
    step(5);
    chk("rf_valid", 32'(valid), 32'h1f);
    clr_cnt = 1'b1;
    step(1);
    clr_cnt = 1'b0;
    chk("clr_scnt",  32'(stall_cnt), 32'h0);
    chk("clr_flcnt", 32'(flush_cnt), 32'h0);

    // Blocked redirect, then released
    redirect = 1'b1; stall = 5'b00100;
    settle();
    chk("br_flush0", 32'(flush), 32'h0);
    step(1);
    chk("br_valid", 32'(valid), 32'h17);
    stall = '0;
    settle();
    chk("br_flush1", 32'(flush), 32'h1);
    step(1);
    chk("br_valid2", 32'(valid), 32'h08);
    settle();
    chk("br_flush2", 32'(flush), 32'h0);
    redirect = 1'b0;
    chk("br_flcnt", 32'(flush_cnt), 32'h1);
    chk("br_scnt",  32'(stall_cnt), 32'h00111);

    // Saturation and clear under stall
    clr_cnt = 1'b1;
    step(1);
    clr_cnt = 1'b0;
    step(5);
    chk("sat_full", 32'(valid), 32'h1f);
    stall = 5'b10000;
    step(20);
    settle();
    chk("sat_scnt",    32'(stall_cnt), 32'hfffff);
    chk("sat_retire",  32'(retire),    32'h0);
    chk("sat_feready", 32'(fe_ready),  32'h0);
    clr_cnt = 1'b1;
    step(1);
    clr_cnt = 1'b0;
    chk("sat_clr", 32'(stall_cnt), 32'h0);
    stall = '0;

    // Reset mid-run
    stall = 5'b00010;
    step(2);
    chk("rr_pre_scnt", 32'(stall_cnt), 32'h00022);
    rst_n = 1'b0; stall = '1; redirect = 1'b1; fe_valid = 1'b1;
    step(1);
    settle();
    chk("rr_valid",   32'(valid),     32'h0);
    chk("rr_scnt",    32'(stall_cnt), 32'h0);
    chk("rr_flcnt",   32'(flush_cnt), 32'h0);
    chk("rr_retire",  32'(retire),    32'h0);
    chk("rr_feready", 32'(fe_ready),  32'h1);
    rst_n = 1'b1; stall = '0; redirect = 1'b0; fe_valid = 1'b0;
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
